// File: rtl/game_pkg.sv
// Shared types and helpers for the enemy scheduler and its LFSR.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    GAME_OVER = 2'd2
  } state_t;

  localparam int          N_ENEMIES_DEF = 8;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;

  // Number of set bits in a 16-bit vector (0..16).
  function automatic logic [4:0] popcount(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) c += 5'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/enemy_scheduler_lfsr16.sv
// 16-bit Galois LFSR that advances only when step is high.
module lfsr16
  import game_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  output logic [15:0] q
);

  logic [15:0] r_q;

  // Shift right, folding the tap mask in when the bit leaving is 1.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst)       r_q <= SEED;
    else if (step) r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_TAPS : 16'h0000);
  end

  assign q = r_q;

endmodule

// File: rtl/enemy_scheduler.sv
// Game-level sequencer: spawn timer, round-robin slot pick, scoring, lives and difficulty ramp.
module enemy_scheduler
  import game_pkg::*;
#(
  parameter int          N_ENEMIES    = N_ENEMIES_DEF,
  parameter int          SPAWN_PERIOD = 50_000_000,
  parameter int          MIN_PERIOD   = 6_250_000,
  parameter int          TIMER_W      = 26,
  parameter int          START_LIVES  = 3,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N_ENEMIES-1:0] alive_i,
  input  logic [N_ENEMIES-1:0] killed_i,
  input  logic [N_ENEMIES-1:0] collision_i,
  output logic [N_ENEMIES-1:0] spawn_o,
  output logic [3:0]           new_angle,
  output logic [1:0]           new_kind,
  output logic [15:0]          score,
  output logic [1:0]           lives,
  output logic                 game_over
);

  localparam int                 PTR_W   = $clog2(N_ENEMIES);
  localparam logic [TIMER_W-1:0] SPAWN_P = TIMER_W'(SPAWN_PERIOD);
  localparam logic [TIMER_W-1:0] MIN_P   = TIMER_W'(MIN_PERIOD);
  localparam logic [1:0]         LIVES0  = 2'(START_LIVES);

  state_t               r_state, w_state_next;
  logic [TIMER_W-1:0]   r_timer, r_period;
  logic                 r_pending;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [N_ENEMIES-1:0] r_col_d, r_spawn;
  logic [3:0]           r_kill_cnt, r_angle;
  logic [1:0]           r_kind, r_lives;
  logic [15:0]          r_score;

  logic [N_ENEMIES-1:0] w_life_evt, w_score_evt;
  logic [4:0]           w_life_cnt, w_score_cnt, w_kill_sum;
  logic [16:0]          w_score_sum;
  logic [1:0]           w_lives_next;
  logic [TIMER_W-1:0]   w_period_dec;
  logic                 w_run, w_enter_run, w_tc, w_found, w_do_spawn, w_lives_zero;
  logic [PTR_W-1:0]     w_slot;
  logic [15:0]          w_lfsr;
  logic                 w_lfsr_unused;

  // First slot not busy, scanning upward from ptr with wrap; MSB flags success.
  function automatic logic [PTR_W:0] find_free(input logic [N_ENEMIES-1:0] busy,
                                               input logic [PTR_W-1:0] ptr);
    logic             found;
    logic [PTR_W-1:0] idx;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < N_ENEMIES; k++) begin
      int s;
      s = (int'(ptr) + k) % N_ENEMIES;
      if (!found && !busy[s]) begin
        found = 1'b1;
        idx   = PTR_W'(s);
      end
    end
    return {found, idx};
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .step (w_do_spawn),
    .q    (w_lfsr)
  );

  // Only the low six LFSR bits feed angle/kind.
  assign w_lfsr_unused = ^w_lfsr[15:6];

  // Event decoding, saturating arithmetic and the spawn decision.
  always_comb begin
    w_run        = (r_state == RUN);
    w_enter_run  = (r_state != RUN) && start;
    w_life_evt   = collision_i & ~r_col_d;
    w_score_evt  = killed_i & ~collision_i & ~r_col_d;
    w_life_cnt   = popcount(16'(w_life_evt));
    w_score_cnt  = popcount(16'(w_score_evt));
    w_lives_next = (w_life_cnt >= {3'b000, r_lives}) ? 2'd0 : r_lives - w_life_cnt[1:0];
    w_lives_zero = w_run && (w_lives_next == 2'd0);
    w_score_sum  = {1'b0, r_score} + 17'(w_score_cnt);
    w_kill_sum   = {1'b0, r_kill_cnt} + w_score_cnt;
    w_period_dec = r_period - (r_period >> 3);
    if (w_period_dec < MIN_P) w_period_dec = MIN_P;
    // A period shrunk below the running timer still terminates on the next cycle.
    w_tc         = (r_timer >= r_period - TIMER_W'(1));
    // A slot strobed last cycle counts as busy until its alive flag rises.
    {w_found, w_slot} = find_free(alive_i | r_spawn, r_rr_ptr);
    w_do_spawn   = w_run && r_pending && w_found && !w_lives_zero;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    // NOTE: defaulting every always_comb output first means no path leaves it unassigned, so no latch.
    w_state_next = r_state;
    unique case (r_state)
      IDLE:      if (start) w_state_next = RUN;
      RUN:       if (w_lives_zero) w_state_next = GAME_OVER;
      GAME_OVER: if (start) w_state_next = RUN;
      default:   w_state_next = IDLE;
    endcase
  end

  // Game datapath: timer, pending spawn, outputs, score, lives and difficulty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_timer    <= '0;
      r_period   <= SPAWN_P;
      r_pending  <= 1'b0;
      r_rr_ptr   <= '0;
      r_col_d    <= '0;
      r_spawn    <= '0;
      r_kill_cnt <= '0;
      r_angle    <= '0;
      r_kind     <= '0;
      r_score    <= '0;
      r_lives    <= LIVES0;
    end else begin
      r_col_d <= collision_i;
      r_spawn <= '0;
      if (w_enter_run) begin
        r_score   <= '0;
        r_lives   <= LIVES0;
        r_period  <= SPAWN_P;
        r_timer   <= '0;
        r_pending <= 1'b0;
      end else if (w_run) begin
        r_timer    <= w_tc ? '0 : r_timer + TIMER_W'(1);
        r_score    <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
        r_lives    <= w_lives_next;
        r_kill_cnt <= w_kill_sum[3:0];
        if (w_kill_sum[4]) r_period <= w_period_dec;
        if (w_do_spawn) begin
          r_spawn   <= N_ENEMIES'(1) << w_slot;
          r_angle   <= w_lfsr[3:0];
          r_kind    <= w_lfsr[5:4];
          r_pending <= 1'b0;
          r_rr_ptr  <= (w_slot == PTR_W'(N_ENEMIES - 1)) ? '0 : w_slot + PTR_W'(1);
        end
        if (w_tc) r_pending <= 1'b1;
      end
    end
  end

  assign spawn_o   = r_spawn;
  assign new_angle = r_angle;
  assign new_kind  = r_kind;
  assign score     = r_score;
  assign lives     = r_lives;
  assign game_over = (r_state == GAME_OVER);

endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed bench for enemy_scheduler: a fast-spawn instance and a ramp instance share stimulus.
module tb_enemy_scheduler;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] alive, killed, col;

  logic [7:0]  spawn, spawn_r;
  logic [3:0]  angle, angle_r;
  logic [1:0]  kind, kind_r;
  logic [15:0] score, score_r;
  logic [1:0]  lives, lives_r;
  logic        go, go_r;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [7:0]  killed;
    logic [7:0]  col;
    logic [15:0] exp_score;
    logic [1:0]  exp_lives;
    logic        exp_go;
  } vec_t;

  vec_t tbl [12];

  enemy_scheduler #(
    .N_ENEMIES(8), .SPAWN_PERIOD(4), .MIN_PERIOD(2), .TIMER_W(26),
    .START_LIVES(3), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .alive_i(alive), .killed_i(killed),
    .collision_i(col), .spawn_o(spawn), .new_angle(angle), .new_kind(kind),
    .score(score), .lives(lives), .game_over(go)
  );

  enemy_scheduler #(
    .N_ENEMIES(8), .SPAWN_PERIOD(64), .MIN_PERIOD(40), .TIMER_W(26),
    .START_LIVES(3), .LFSR_SEED(16'hACE1)
  ) dut_r (
    .clk(clk), .rst(rst), .start(start), .alive_i(alive), .killed_i(killed),
    .collision_i(col), .spawn_o(spawn_r), .new_angle(angle_r), .new_kind(kind_r),
    .score(score_r), .lives(lives_r), .game_over(go_r)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ticks until the ramp instance strobes; n is the number of cycles waited.
  task automatic wait_spawn_r(output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      tick();
      n++;
      if (spawn_r != 8'h00) seen = 1'b1;
    end
    check("spawn_r_seen", 32'(seen), 32'd1);
  endtask

  // Sixteen shot kills: one kill_cnt wrap.
  task automatic ramp();
    killed = 8'hFF;
    tick();
    tick();
    killed = 8'h00;
    tick();
  endtask

  initial begin
    int n;
    tbl[0]  = '{8'h04, 8'h00, 16'd1, 2'd3, 1'b0};
    tbl[1]  = '{8'h00, 8'h00, 16'd1, 2'd3, 1'b0};
    tbl[2]  = '{8'h09, 8'h00, 16'd3, 2'd3, 1'b0};
    tbl[3]  = '{8'h00, 8'h20, 16'd3, 2'd2, 1'b0};
    tbl[4]  = '{8'h20, 8'h20, 16'd3, 2'd2, 1'b0};
    tbl[5]  = '{8'h00, 8'h00, 16'd3, 2'd2, 1'b0};
    tbl[6]  = '{8'h02, 8'h20, 16'd4, 2'd1, 1'b0};
    tbl[7]  = '{8'h20, 8'h20, 16'd4, 2'd1, 1'b0};
    tbl[8]  = '{8'h00, 8'h00, 16'd4, 2'd1, 1'b0};
    tbl[9]  = '{8'h40, 8'h23, 16'd5, 2'd0, 1'b1};
    tbl[10] = '{8'hFF, 8'h00, 16'd5, 2'd0, 1'b1};
    tbl[11] = '{8'h00, 8'h10, 16'd5, 2'd0, 1'b1};

    rst = 1'b1; start = 1'b0; alive = 8'h00; killed = 8'h00; col = 8'h00;
    tick();
    tick();
    check("rst_spawn", spawn, 8'h00);
    check("rst_score", score, 16'd0);
    check("rst_lives", lives, 2'd3);
    check("rst_go", go, 1'b0);
    rst = 1'b0;
    tick();
    check("idle_no_spawn", spawn, 8'h00);

    // First spawns after start: slot 0 at cycle 5, slot 1 four cycles later.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 4; k++) begin tick(); check("t1_quiet_a", spawn, 8'h00); end
    tick();
    check("t1_spawn0", spawn, 8'h01);
    check("t1_angle0", angle, 4'h1);
    check("t1_kind0", kind, 2'd2);
    for (int k = 0; k < 3; k++) begin tick(); check("t1_quiet_b", spawn, 8'h00); end
    tick();
    check("t1_spawn1", spawn, 8'h02);
    check("t1_angle1", angle, 4'h0);
    check("t1_kind1", kind, 2'd3);

    // All slots busy, then one slot frees up.
    alive = 8'hFF;
    for (int k = 0; k < 20; k++) begin tick(); check("t2_full", spawn, 8'h00); end
    alive = 8'hF7;
    tick();
    check("t2_spawn3", spawn, 8'h08);
    alive = 8'hFF;
    tick();
    check("t2_single_a", spawn, 8'h00);
    tick();
    check("t2_single_b", spawn, 8'h00);

    // Reset in the middle of a run with a spawn pending.
    killed = 8'h01;
    tick();
    killed = 8'h00;
    check("t6_pre_score", score, 16'd1);
    col = 8'h01;
    tick();
    col = 8'h00;
    check("t6_pre_lives", lives, 2'd2);
    repeat (6) tick();
    rst = 1'b1;
    alive = 8'h00;
    tick();
    check("t6_spawn", spawn, 8'h00);
    check("t6_score", score, 16'd0);
    check("t6_lives", lives, 2'd3);
    check("t6_go", go, 1'b0);
    check("t6_spawn_r", spawn_r, 8'h00);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin tick(); check("t6_idle", spawn, 8'h00); end

    // Score and lives event table.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("tbl_start_score", score, 16'd0);
    check("tbl_start_lives", lives, 2'd3);
    for (int i = 0; i < 12; i++) begin
      killed = tbl[i].killed;
      col    = tbl[i].col;
      tick();
      check($sformatf("tbl%0d_score", i), score, tbl[i].exp_score);
      check($sformatf("tbl%0d_lives", i), lives, tbl[i].exp_lives);
      check($sformatf("tbl%0d_go", i), go, tbl[i].exp_go);
    end
    killed = 8'h00;
    col    = 8'h00;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("go_no_spawn", spawn, 8'h00);
      check("go_hold", go, 1'b1);
    end

    // Restart from GAME_OVER.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("restart_lives", lives, 2'd3);
    check("restart_score", score, 16'd0);
    check("restart_go", go, 1'b0);
    repeat (4) tick();
    tick();
    check("restart_spawn", 32'($onehot(spawn)), 32'd1);

    // Score saturation.
    killed = 8'hFF;
    repeat (8191) tick();
    killed = 8'h3F;
    tick();
    check("sat_fffe", score, 16'hFFFE);
    killed = 8'h07;
    tick();
    check("sat_ffff", score, 16'hFFFF);
    killed = 8'h01;
    tick();
    check("sat_hold", score, 16'hFFFF);
    killed = 8'h00;
    check("sat_lives", lives, 2'd3);

    // Difficulty ramp on the 64-cycle instance.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    killed = 8'hFF;
    tick();
    tick();
    killed = 8'h00;
    check("ramp_score", score_r, 16'd16);
    wait_spawn_r(n);
    wait_spawn_r(n);
    check("ramp_period56", n, 32'd56);
    ramp();
    wait_spawn_r(n);
    wait_spawn_r(n);
    check("ramp_period49", n, 32'd49);
    repeat (4) ramp();
    wait_spawn_r(n);
    wait_spawn_r(n);
    check("ramp_floor40", n, 32'd40);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
